// File: rtl/maze_path_checker.sv
// maze_path_checker: checks the 17x17 maze solver's answer stream.
// Snoops the serial maze (row-major, one cell per maze_valid cycle), then
// walks the solver's direction stream from (0,0) and reports a verdict.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   maze_valid   maze bit valid;  maze_in  cell value, 1 = road, 0 = wall
//   dir_valid    direction valid; dir_in   0 RIGHT, 1 DOWN, 2 LEFT, 3 UP
//   done         one-cycle pulse when the verdict is valid
//   pass         path legal and ends at the far corner; held
//   err_code     first error seen (0 none .. 7 protocol); held
//   step_count   accepted moves incl. the faulting one, saturating; held
module maze_path_checker #(
  parameter int unsigned MAZE_WIDTH = 17,
  parameter int unsigned TIMEOUT    = 3000,
  parameter int unsigned CNT_WIDTH  = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 maze_valid,
  input  logic                 maze_in,
  input  logic                 dir_valid,
  input  logic [1:0]           dir_in,
  output logic                 done,
  output logic                 pass,
  output logic [2:0]           err_code,
  output logic [CNT_WIDTH-1:0] step_count
);

  localparam int unsigned CELLS  = MAZE_WIDTH * MAZE_WIDTH;
  localparam int unsigned IDX_W  = $clog2(CELLS);
  localparam int unsigned POS_W  = $clog2(MAZE_WIDTH);
  localparam int unsigned SPOS_W = POS_W + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(CELLS - 1);
  localparam logic [POS_W-1:0]         MAX_POS   = POS_W'(MAZE_WIDTH - 1);
  localparam logic signed [SPOS_W-1:0] MAX_POS_S = SPOS_W'(MAZE_WIDTH - 1);
  localparam logic signed [SPOS_W-1:0] ZERO_S    = '0;
  localparam logic signed [SPOS_W-1:0] ONE_S     = SPOS_W'(1);
  localparam logic [TMO_W-1:0]         TMO_LIMIT = TMO_W'(TIMEOUT);

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_SHORT      = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd2;
  localparam logic [2:0] ERR_OOB        = 3'd3;
  localparam logic [2:0] ERR_WALL       = 3'd4;
  localparam logic [2:0] ERR_OVERRUN    = 3'd5;
  localparam logic [2:0] ERR_INCOMPLETE = 3'd6;
  localparam logic [2:0] ERR_PROTOCOL   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_WALK,
    S_FLUSH,
    S_REPORT
  } state_t;

  state_t             state;
  logic [CELLS-1:0]   grid;
  logic [IDX_W-1:0]   idx;
  logic [TMO_W-1:0]   tcnt;
  logic [POS_W-1:0]   row;
  logic [POS_W-1:0]   col;

  logic signed [SPOS_W-1:0] row_s;
  logic signed [SPOS_W-1:0] col_s;
  logic signed [SPOS_W-1:0] next_row;
  logic signed [SPOS_W-1:0] next_col;
  logic [IDX_W-1:0]         tgt_idx;
  logic                     oob;
  logic                     at_goal;
  logic                     start;
  logic                     move_en;
  logic [2:0]               move_err;

  assign row_s = $signed({1'b0, row});
  assign col_s = $signed({1'b0, col});

  // Candidate move: signed target so stepping off either edge is caught.
  always_comb begin
    next_row = row_s;
    next_col = col_s;
    unique case (dir_in)
      2'd0:    next_col = col_s + ONE_S;
      2'd1:    next_row = row_s + ONE_S;
      2'd2:    next_col = col_s - ONE_S;
      default: next_row = row_s - ONE_S;
    endcase
    oob = (next_row < ZERO_S) || (next_row > MAX_POS_S) ||
          (next_col < ZERO_S) || (next_col > MAX_POS_S);
    tgt_idx = '0;
    if (!oob) begin
      tgt_idx = IDX_W'($unsigned(next_row)) * IDX_W'(MAZE_WIDTH) +
                IDX_W'($unsigned(next_col));
    end
  end

  assign at_goal = (row == MAX_POS) && (col == MAX_POS);

  // Move error, highest priority first: protocol, overrun, out of bounds, wall.
  always_comb begin
    move_err = ERR_NONE;
    if (maze_valid)          move_err = ERR_PROTOCOL;
    else if (at_goal)        move_err = ERR_OVERRUN;
    else if (oob)            move_err = ERR_OOB;
    else if (!grid[tgt_idx]) move_err = ERR_WALL;
  end

  // A maze may start from IDLE or in the REPORT cycle itself.
  assign start   = maze_valid && ((state == S_IDLE) || (state == S_REPORT));
  // In WAIT a concurrent maze_valid is a protocol error, not a move.
  assign move_en = dir_valid && (((state == S_WAIT) && !maze_valid) || (state == S_WALK));

  // Checker FSM with registered verdict outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grid       <= '0;
      idx        <= '0;
      tcnt       <= '0;
      row        <= '0;
      col        <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_code   <= ERR_NONE;
      step_count <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        grid[0]    <= maze_in;
        idx        <= IDX_W'(1);
        row        <= '0;
        col        <= '0;
        pass       <= 1'b0;
        err_code   <= ERR_NONE;
        step_count <= '0;
        state      <= S_LOAD;
      end else if (move_en) begin
        if (step_count != '1) step_count <= step_count + CNT_WIDTH'(1);
        if (move_err != ERR_NONE) begin
          err_code <= move_err;
          state    <= S_FLUSH;
        end else begin
          row   <= POS_W'($unsigned(next_row));
          col   <= POS_W'($unsigned(next_col));
          state <= S_WALK;
        end
      end else begin
        unique case (state)
          S_IDLE: ;
          S_LOAD: begin
            if (dir_valid) begin
              err_code <= ERR_PROTOCOL;
              state    <= S_FLUSH;
            end else if (!maze_valid) begin
              err_code <= ERR_SHORT;
              done     <= 1'b1;
              state    <= S_REPORT;
            end else begin
              grid[idx] <= maze_in;
              if (idx == LAST_IDX) begin
                tcnt  <= '0;
                state <= S_WAIT;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          S_WAIT: begin
            if (maze_valid) begin
              err_code <= ERR_PROTOCOL;
              done     <= 1'b1;
              state    <= S_REPORT;
            end else if (tcnt == TMO_LIMIT) begin
              err_code <= ERR_TIMEOUT;
              done     <= 1'b1;
              state    <= S_REPORT;
            end else begin
              tcnt <= tcnt + TMO_W'(1);
            end
          end
          S_WALK: begin
            // Stream ended (dir_valid low): verdict depends on final position.
            if (at_goal) pass <= 1'b1;
            else         err_code <= ERR_INCOMPLETE;
            done  <= 1'b1;
            state <= S_REPORT;
          end
          S_FLUSH: begin
            if (!dir_valid) begin
              done  <= 1'b1;
              state <= S_REPORT;
            end
          end
          S_REPORT: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
